mux_flop_piso_ctrl: RTL and testbench

//  Sequencer for a WIDTH-bit bank of mux-select flops (D0/D1 steered by select, clock-enabled), used as a

---
 rtl/mux_flop_piso_ctrl.sv | 102 ++++++++++
 tb/tb_mux_flop_piso_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_flop_piso_ctrl.sv
// Parallel-in/serial-out sequencer driving a bank of mux-select flops.
// Loads words over REQ/ACK and streams them bit-by-bit under valid/ready.
module mux_flop_piso_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             LOAD_REQ,
  input  logic [WIDTH-1:0] PDATA,
  output logic             LOAD_ACK,
  output logic             SOUT,
  output logic             SVALID,
  output logic             SLAST,
  input  logic             SREADY,
  output logic             BUSY,
  output logic             SD_O,
  output logic             SP_O
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bank_q, bank_d, shifted;
  logic [CW-1:0]    count_q, count_d;
  logic             ack_q, ack_d;
  logic             acc, last;

  // ACK-cycle blocking keeps a still-high REQ from loading the same word twice
  assign acc  = LOAD_REQ & ~ack_q;
  assign last = (state_q == ST_SHIFT) && (count_q == CW'(WIDTH - 1));

  always_comb begin
    if (MSB_FIRST) shifted = {bank_q[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, bank_q[WIDTH-1:1]};
  end

  always_comb begin
    SD_O    = 1'b0;
    SP_O    = 1'b0;
    state_d = state_q;
    bank_d  = bank_q;
    count_d = count_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          SD_O = 1'b1;
          SP_O = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (SREADY) begin
          if (!last) begin
            SP_O = 1'b1;
          end else if (acc) begin
            SD_O = 1'b1;
            SP_O = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Bank/counter updates follow the select/enable actually presented to the bank
    if (SP_O) begin
      if (SD_O) begin
        bank_d  = PDATA;
        count_d = '0;
        ack_d   = 1'b1;
        state_d = ST_SHIFT;
      end else begin
        bank_d  = shifted;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      count_q <= count_d;
      ack_q   <= ack_d;
    end
  end

  assign LOAD_ACK = ack_q;
  assign SVALID   = (state_q == ST_SHIFT);
  assign BUSY     = (state_q == ST_SHIFT);
  assign SLAST    = last;
  assign SOUT     = SVALID & (MSB_FIRST ? bank_q[WIDTH-1] : bank_q[0]);

endmodule

// File: tb/tb_mux_flop_piso_ctrl.sv
// Bench for mux_flop_piso_ctrl: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a word/index model of the serial stream.
module tb_mux_flop_piso_ctrl;
  localparam int W = 8;

  logic         CK = 1'b0;
  logic         RSTN = 1'b0;
  logic         LOAD_REQ = 1'b0;
  logic         SREADY = 1'b0;
  logic [W-1:0] PDATA = '0;

  logic ack_m, sout_m, sval_m, slast_m, busy_m, sd_m, sp_m;
  logic ack_l, sout_l, sval_l, slast_l, busy_l, sd_l, sp_l;

  mux_flop_piso_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .CK(CK), .RSTN(RSTN), .LOAD_REQ(LOAD_REQ), .PDATA(PDATA), .LOAD_ACK(ack_m),
    .SOUT(sout_m), .SVALID(sval_m), .SLAST(slast_m), .SREADY(SREADY), .BUSY(busy_m),
    .SD_O(sd_m), .SP_O(sp_m));

  mux_flop_piso_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .CK(CK), .RSTN(RSTN), .LOAD_REQ(LOAD_REQ), .PDATA(PDATA), .LOAD_ACK(ack_l),
    .SOUT(sout_l), .SVALID(sval_l), .SLAST(slast_l), .SREADY(SREADY), .BUSY(busy_l),
    .SD_O(sd_l), .SP_O(sp_l));

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: current word, how many of its bits have been accepted, and the ACK flag
  logic         m_busy, m_ack;
  logic [W-1:0] m_word;
  int           m_idx;

  always @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      m_busy = 1'b0; m_ack = 1'b0; m_word = '0; m_idx = 0;
    end else begin
      logic a;
      a = LOAD_REQ && !m_ack;
      m_ack = 1'b0;
      if (!m_busy) begin
        if (a) begin m_busy = 1'b1; m_word = PDATA; m_idx = 0; m_ack = 1'b1; end
      end else if (SREADY) begin
        if (m_idx < W - 1) m_idx++;
        else if (a) begin m_word = PDATA; m_idx = 0; m_ack = 1'b1; end
        else m_busy = 1'b0;
      end
    end
  end

  always @(negedge CK) begin
    logic a, lst, esp, esd;
    a   = LOAD_REQ && !m_ack;
    lst = m_busy && (m_idx == W - 1);
    esp = 1'b0; esd = 1'b0;
    if (!m_busy) begin esp = a; esd = a; end
    else if (SREADY) begin
      if (!lst) esp = 1'b1;
      else if (a) begin esp = 1'b1; esd = 1'b1; end
    end
    chk("ack_msb",   ack_m,   m_ack);
    chk("ack_lsb",   ack_l,   m_ack);
    chk("valid_msb", sval_m,  m_busy);
    chk("valid_lsb", sval_l,  m_busy);
    chk("busy_msb",  busy_m,  m_busy);
    chk("busy_lsb",  busy_l,  m_busy);
    chk("last_msb",  slast_m, lst);
    chk("last_lsb",  slast_l, lst);
    chk("sout_msb",  sout_m,  m_busy ? m_word[W-1-m_idx] : 1'b0);
    chk("sout_lsb",  sout_l,  m_busy ? m_word[m_idx] : 1'b0);
    chk("sp_msb",    sp_m,    esp);
    chk("sp_lsb",    sp_l,    esp);
    chk("sd_msb",    sd_m,    esd);
    chk("sd_lsb",    sd_l,    esd);
  end

  // Stream observers used by the literal expectations
  logic [W-1:0] rx_m, rx_l, lastw_m, lastw_l;
  int ack_cnt, sp_cnt, run, maxrun, words;

  always @(negedge CK) begin
    if (ack_m) ack_cnt++;
    if (sp_l) sp_cnt++;
    if (sval_m) begin run++; if (run > maxrun) maxrun = run; end
    else run = 0;
    if (sval_m && SREADY) begin
      rx_m = {rx_m[W-2:0], sout_m};
      rx_l = {sout_l, rx_l[W-1:1]};
      if (slast_m) begin lastw_m = rx_m; lastw_l = rx_l; words++; end
    end
  end

  task automatic clr();
    ack_cnt = 0; sp_cnt = 0; run = 0; maxrun = 0; words = 0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!ack_m && n < 40) begin @(posedge CK); #1; n++; end
    if (!ack_m) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ACK expected ACK within 40 cycles");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_m && n < 100) begin @(posedge CK); #1; n++; end
    if (busy_m) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got BUSY=1 expected BUSY=0 within 100 cycles");
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    LOAD_REQ = 1'b1; PDATA = d;
    @(posedge CK); #1;
    wait_ack(n);
    LOAD_REQ = 1'b0;
  endtask

  initial begin
    int n;
    rx_m = '0; rx_l = '0; lastw_m = '0; lastw_l = '0;
    clr();
    repeat (3) @(posedge CK);
    #1;
    chk("reset_valid", sval_m, 0);
    chk("reset_ack", ack_m, 0);
    @(posedge CK); #2 RSTN = 1'b1;
    @(posedge CK); #1;
    SREADY = 1'b1;

    // A5 MSB/LSB first, continuous ready
    clr(); send(8'hA5); wait_idle();
    chk("t1_word_msb", lastw_m, 8'hA5);
    chk("t1_word_lsb", lastw_l, 8'hA5);
    chk("t1_acks", ack_cnt, 1);
    chk("t1_run", maxrun, 8);

    // 01: one load edge plus seven shift edges
    @(posedge CK); #1;
    clr(); send(8'h01); wait_idle();
    chk("t2_sp_edges", sp_cnt, 8);
    chk("t2_word_lsb", lastw_l, 8'h01);

    // Four-cycle stall at bit 3
    @(posedge CK); #1;
    clr(); send(8'h6B);
    repeat (3) @(posedge CK);
    #1 SREADY = 1'b0;
    repeat (4) @(posedge CK);
    #1 SREADY = 1'b1;
    wait_idle();
    chk("t3_word_msb", lastw_m, 8'h6B);
    chk("t3_word_lsb", lastw_l, 8'h6B);
    chk("t3_run", maxrun, 12);

    // Back-to-back with REQ held throughout
    @(posedge CK); #1;
    clr();
    LOAD_REQ = 1'b1; PDATA = 8'hFF;
    @(posedge CK); #1;
    wait_ack(n);
    PDATA = 8'h00;
    @(posedge CK); #1;
    wait_ack(n);
    chk("t4_second_ack_wait", n, 7);
    LOAD_REQ = 1'b0;
    wait_idle();
    chk("t4_acks", ack_cnt, 2);
    chk("t4_run", maxrun, 16);
    chk("t4_words", words, 2);
    chk("t4_word_msb", lastw_m, 8'h00);

    // Request arriving at bit 2 waits for the final bit
    @(posedge CK); #1;
    clr(); send(8'hC3);
    repeat (2) @(posedge CK);
    #1;
    LOAD_REQ = 1'b1; PDATA = 8'h3C;
    wait_ack(n);
    LOAD_REQ = 1'b0;
    chk("t5_ack_wait", n, 6);
    wait_idle();
    chk("t5_acks", ack_cnt, 2);
    chk("t5_run", maxrun, 16);
    chk("t5_word_lsb", lastw_l, 8'h3C);

    // Asynchronous reset mid-word with a pending request
    @(posedge CK); #1;
    clr(); send(8'h96);
    repeat (4) @(posedge CK);
    #1;
    LOAD_REQ = 1'b1; PDATA = 8'h5A;
    #2 RSTN = 1'b0;
    #1;
    chk("t6_rst_valid", sval_m, 0);
    chk("t6_rst_busy", busy_l, 0);
    chk("t6_rst_last", slast_m, 0);
    chk("t6_rst_sout", sout_m | sout_l, 0);
    chk("t6_rst_ack", ack_m, 0);
    repeat (2) @(posedge CK);
    chk("t6_no_ack_in_reset", ack_cnt, 1);
    #2 RSTN = 1'b1;
    @(posedge CK); #1;
    wait_ack(n);
    LOAD_REQ = 1'b0;
    wait_idle();
    chk("t6_acks", ack_cnt, 2);
    chk("t6_word_msb", lastw_m, 8'h5A);

    // Randomized traffic and backpressure
    for (int c = 0; c < 1500; c++) begin
      @(posedge CK); #1;
      SREADY = ($urandom_range(0, 3) != 0);
      if (ack_m) LOAD_REQ = 1'b0;
      else if (!LOAD_REQ && $urandom_range(0, 2) == 0) begin
        LOAD_REQ = 1'b1;
        PDATA = W'($urandom);
      end
    end
    LOAD_REQ = 1'b0; SREADY = 1'b1;
    wait_idle();
    repeat (2) @(posedge CK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
